// File: rtl/cdc_pkg.sv
// Shared types for the req/ack clock-domain-crossing handshake blocks.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } cdc_hs_state_t;

endpackage

// File: rtl/cdc_2ff_sync.sv
// Two-flop synchronizer; each bit is treated as an independent level.
module cdc_2ff_sync #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cdc_hs_src.sv
// Source side of a 4-phase req/ack word transfer into another clock domain.
module cdc_hs_src
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  req_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ack_i,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

    cdc_hs_state_t state;
    logic          ack_s;
    logic [CW-1:0] cnt;
    logic          wdog_run;

    cdc_2ff_sync #(
        .DATA_WIDTH(1)
    ) u_ack_sync (
        .clk(clk),
        .rst(rst),
        .d  (ack_i),
        .q  (ack_s)
    );

    assign in_ready = (state == IDLE) && !ack_s;
    assign busy_o   = (state != IDLE);
    assign wdog_run = (TIMEOUT_CYCLES != 0) && (cnt != TMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            req_o  <= 1'b0;
            data_o <= '0;
            done_o <= 1'b0;
            cnt    <= '0;
            err_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_o <= in_data;
                        req_o  <= 1'b1;
                        cnt    <= '0;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        req_o <= 1'b0;
                        cnt   <= '0;
                        state <= REL;
                    end else if (wdog_run) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == TLAST) err_o <= 1'b1;
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end else if (wdog_run) begin
                        // A stuck ack is flagged but the handshake is kept alive.
                        cnt <= cnt + CW'(1);
                        if (cnt == TLAST) err_o <= 1'b1;
                    end
                end
                default: begin
                    req_o <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_hs_src.sv
// Directed bench for cdc_hs_src with a cycle-counting ack responder.
module tb_cdc_hs_src;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       req_o;
    logic [7:0] data_o;
    logic       ack_i;
    logic       done_o;
    logic       busy_o;
    logic       err_o;

    int  n_chk  = 0;
    int  n_fail = 0;
    int  n_done = 0;
    bit  auto_ack = 1'b0;
    bit  ack_man  = 1'b0;
    int  cyc;
    int  d0;

    cdc_hs_src #(
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .req_o   (req_o),
        .data_o  (data_o),
        .ack_i   (ack_i),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Destination stand-in: raise ack 3 cycles after req, drop 3 after release.
    task automatic ack_model();
        int  hi = 0;
        int  lo = 0;
        logic a = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!auto_ack) begin
                hi = 0;
                lo = 0;
                a  = ack_man;
            end else if (req_o && !a) begin
                hi++;
                if (hi == 3) begin
                    a  = 1'b1;
                    hi = 0;
                end
            end else if (!req_o && a) begin
                lo++;
                if (lo == 3) begin
                    a  = 1'b0;
                    lo = 0;
                end
            end else begin
                hi = 0;
                lo = 0;
            end
            ack_i = a;
        end
    endtask

    task automatic monitor();
        logic       req_prev = 1'b0;
        logic [7:0] held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (done_o) n_done++;
            if (req_o && !req_prev) begin
                held = data_o;
                check("req_rise_ack_s", 32'(dut.ack_s), 32'd0);
            end else if (req_o) begin
                check("data_hold", 32'(data_o), 32'(held));
            end
            req_prev = req_o;
        end
    endtask

    task automatic wait_done(input string tag, input int limit,
                             output int c);
        c = 0;
        while (c < limit) begin
            step(1);
            c++;
            if (done_o) break;
        end
        check({tag, "_done"}, 32'(done_o), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        ack_i    = 1'b0;
        fork
            ack_model();
            monitor();
        join_none

        #12;
        check("rst_req", 32'(req_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        step(1);
        rst      = 1'b0;
        auto_ack = 1'b1;
        step(2);

        // single transfer
        d0       = n_done;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step(1);
        in_valid = 1'b0;
        in_data  = 8'h00;
        check("t1_req", 32'(req_o), 32'd1);
        check("t1_data", 32'(data_o), 32'hA5);
        check("t1_busy", 32'(busy_o), 32'd1);
        check("t1_ready", 32'(in_ready), 32'd0);
        wait_done("t1", 40, cyc);
        check("t1_latency", 32'(cyc), 32'd10);
        check("t1_ready_done", 32'(in_ready), 32'd1);
        check("t1_busy_done", 32'(busy_o), 32'd0);
        step(1);
        check("t1_done_pulse", 32'(done_o), 32'd0);
        check("t1_ndone", 32'(n_done - d0), 32'd1);
        check("t1_err", 32'(err_o), 32'd0);
        check("t1_data_kept", 32'(data_o), 32'hA5);

        // back-to-back with valid held high
        d0       = n_done;
        in_valid = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            in_data = 8'(w);
            cyc = 0;
            while (!in_ready && cyc < 50) begin
                step(1);
                cyc++;
            end
            check("b2b_ready", 32'(in_ready), 32'd1);
            step(1);
            check("b2b_req", 32'(req_o), 32'd1);
            check("b2b_data", 32'(data_o), 32'(w));
            in_data = 8'hEE;
        end
        in_valid = 1'b0;
        wait_done("b2b", 40, cyc);
        step(1);
        check("b2b_ndone", 32'(n_done - d0), 32'd4);
        check("b2b_data_last", 32'(data_o), 32'h04);

        // stale ack across reset
        auto_ack = 1'b0;
        ack_man  = 1'b1;
        rst      = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step(2);
        check("stale_ready", 32'(in_ready), 32'd0);
        check("stale_busy", 32'(busy_o), 32'd0);
        check("stale_req", 32'(req_o), 32'd0);
        ack_man = 1'b0;
        step(1);
        check("stale_ready_k1", 32'(in_ready), 32'd0);
        step(1);
        check("stale_ready_k2", 32'(in_ready), 32'd1);
        step(1);
        in_valid = 1'b0;
        check("stale_req_acc", 32'(req_o), 32'd1);
        check("stale_data_acc", 32'(data_o), 32'h5A);
        auto_ack = 1'b1;
        wait_done("stale", 40, cyc);

        // watchdog timeout with no ack
        step(1);
        auto_ack = 1'b0;
        ack_man  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        step(1);
        in_valid = 1'b0;
        check("to_req_start", 32'(req_o), 32'd1);
        step(15);
        check("to_err_15", 32'(err_o), 32'd0);
        step(1);
        check("to_err_16", 32'(err_o), 32'd1);
        check("to_req_held", 32'(req_o), 32'd1);
        step(5);
        check("to_req_later", 32'(req_o), 32'd1);
        ack_man = 1'b1;
        cyc = 0;
        while (req_o && cyc < 20) begin
            step(1);
            cyc++;
        end
        check("to_req_drop", 32'(req_o), 32'd0);
        check("to_busy_rel", 32'(busy_o), 32'd1);
        ack_man = 1'b0;
        wait_done("to", 40, cyc);
        check("to_err_sticky", 32'(err_o), 32'd1);
        check("to_data", 32'(data_o), 32'h77);

        // asynchronous reset while requesting
        step(1);
        in_valid = 1'b1;
        in_data  = 8'h99;
        step(1);
        in_valid = 1'b0;
        step(2);
        check("mid_req_before", 32'(req_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_req_async", 32'(req_o), 32'd0);
        check("mid_busy_async", 32'(busy_o), 32'd0);
        check("mid_data_async", 32'(data_o), 32'd0);
        check("mid_err_async", 32'(err_o), 32'd0);
        step(1);
        rst      = 1'b0;
        auto_ack = 1'b1;
        step(2);
        d0       = n_done;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        step(1);
        in_valid = 1'b0;
        check("re_req", 32'(req_o), 32'd1);
        check("re_data", 32'(data_o), 32'h3C);
        wait_done("re", 40, cyc);
        check("re_latency", 32'(cyc), 32'd10);
        step(1);
        check("re_ndone", 32'(n_done - d0), 32'd1);
        check("re_err", 32'(err_o), 32'd0);
        check("re_data_kept", 32'(data_o), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_hs_src.md
# cdc_hs_src

Source-side controller for a 4-phase req/ack handshake that carries a multi-bit word into another clock domain. It accepts a word through a valid/ready interface, holds it stable on `data_o`, and drives `req_o` into the destination domain. It brings the destination's raw `ack_i` back through an internal `cdc_2ff_sync` and sequences the return-to-zero phase. It sits directly upstream of the destination-side synchronizer and directly downstream of its own ack synchronizer.

## Interface
- `DATA_WIDTH`, 8: width of the transferred word.
- `TIMEOUT_CYCLES`, 1024: cycles allowed in one handshake phase before `err_o` sets; 0 disables the watchdog.
- `clk` input 1: source-domain clock.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: upstream word valid.
- `in_ready` output 1: block can accept a word this cycle.
- `in_data` input DATA_WIDTH: upstream word.
- `req_o` output 1: handshake request, registered, to the destination domain.
- `data_o` output DATA_WIDTH: captured word, registered, stable while `req_o`=1.
- `ack_i` input 1: raw acknowledge from the destination domain (asynchronous to `clk`).
- `done_o` output 1: one-cycle pulse when a transfer completes.
- `busy_o` output 1: high in any state other than IDLE.
- `err_o` output 1: sticky watchdog error, cleared only by `rst`.

## Operation
- `ack_s` is `ack_i` after the internal 2-FF synchronizer.
- FSM states:
  - IDLE: `req_o`=0.
  - REQ: `req_o`=1, waiting for `ack_s`=1.
  - REL: `req_o`=0, waiting for `ack_s`=0.
- `in_ready` = (state==IDLE) && !`ack_s`. It is combinational from registered signals only and never depends on `in_valid`.
- Accept on `in_valid && in_ready`:
  - `data_o` <= `in_data`.
  - State goes to REQ.
- `data_o` changes only on accept. It holds its value through REQ, REL and IDLE until the next accept.
- REQ, when `ack_s`=1: go to REL and drop `req_o`.
- REL, when `ack_s`=0: go to IDLE and pulse `done_o` for one cycle, on the transition cycle.
- `ack_s`=1 while in IDLE (a stale or spurious ack) blocks acceptance, because `in_ready`=0. The state does not change.
- Watchdog:
  - Counter of width $clog2(TIMEOUT_CYCLES+1), reset to 0 on entry to REQ and on entry to REL.
  - Increments each cycle in REQ or REL, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES, `err_o` <= 1.
  - The FSM is not aborted: a 4-phase protocol cannot be safely abandoned, so the handshake continues if the ack eventually arrives.
- Reset values: `req_o`=0, `data_o`=0, `done_o`=0, `busy_o`=0, `err_o`=0, state=IDLE, counter=0, synchronizer flops=0.
- Reset mid-transfer: `req_o` drops immediately, asynchronously. The word is lost and the destination must tolerate a request withdrawn early. After reset, `in_ready` stays 0 until `ack_s`=0.

## Timing
- Accept at edge N: `req_o`=1 and `data_o` valid after edge N. `data_o` is set up no later than `req_o` rises.
- `ack_i` rising before edge M: `ack_s`=1 after edge M+1. State is REL and `req_o`=0 after edge M+2.
- `ack_i` falling before edge K: `done_o`=1 and state IDLE after edge K+2. `in_ready`=1 in the same cycle, so the next accept can occur at edge K+3.
- Minimum per-word cost: 1 accept cycle, plus 2 sync cycles for each ack edge, plus the destination's own latency.
- Accept and a transition never coincide, because accept happens only in IDLE.

## Structure
- Package `cdc_pkg` holds `cdc_hs_state_t` (enum: IDLE, REQ, REL, 2 bits).
- Sub-module: one `cdc_2ff_sync` instance with DATA_WIDTH=1 on `ack_i`. No other hierarchy.

## Test plan
- Single transfer: reset, `in_data`=0xA5 with valid; ack model asserts `ack_i` 3 cycles after `req_o` rises, drops it 3 cycles after `req_o` falls -> `data_o`=0xA5 stable while `req_o`=1; exactly one `done_o` pulse; `err_o`=0.
- Back-to-back: 4 words 0x01..0x04 with `in_valid` held high -> each accepted only while IDLE; `data_o` sequence is 0x01..0x04; 4 `done_o` pulses; `req_o` never high while `ack_s`=1 from the previous word.
- Stale ack: hold `ack_i`=1 at reset release, `in_valid`=1 -> `in_ready`=0 until 2 cycles after `ack_i` falls; then accept.
- Timeout: TIMEOUT_CYCLES=16, `ack_i` never rises -> `err_o`=1 exactly 16 cycles after entering REQ; `req_o` stays 1; a later ack completes the transfer and `err_o` stays 1.
- Reset mid-REQ: assert `rst` asynchronously while `req_o`=1 -> `req_o`, `busy_o` and `data_o` go to 0 without a clock edge; after release the bench completes a fresh transfer of 0x3C normally.
